// File: rtl/ro_buffer_pkg.sv
// ro_buffer_pkg: shared sizes, types and helpers for the reorder buffer slice.
//   ROB_SIZE  entry slots (slot 0 reserved as the "no dependency" tag)
//   rob_id_t  rename tag, reg_id_t architectural register id, reg_t data word
//   rob_entry_t per-slot state, fwd_t operand-forwarding lookup result
package ro_buffer_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROB_ID_W = $clog2(ROB_SIZE);
  localparam int REG_ID_W = 5;
  localparam int REG_W    = 32;

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [ROB_ID_W:0]   rob_cnt_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [REG_W-1:0]    reg_t;

  localparam rob_id_t  ROB_NULL  = '0;
  localparam rob_id_t  ROB_FIRST = rob_id_t'(1);
  localparam rob_id_t  ROB_LAST  = rob_id_t'(ROB_SIZE - 1);
  localparam rob_cnt_t ROB_CAP   = rob_cnt_t'(ROB_SIZE - 1);

  typedef struct packed {
    logic    busy;
    logic    ready;
    reg_id_t rd;
    reg_t    value;
  } rob_entry_t;

  typedef struct packed {
    logic hit;
    reg_t value;
  } fwd_t;
endpackage

// File: rtl/ro_buffer_if.sv
// ro_buffer_if: issuer / CDB / register-file bundle around the reorder buffer.
//   master : the reorder buffer side (drives dest/full and commit_*)
//   slave  : the environment side (issuer, CDB, control)
//   rdy    global enable, flush misprediction flush
// With ROB_FORWARD_EN defined the qj/qk operand lookup signals are present.
interface ro_buffer_if;
  import ro_buffer_pkg::*;

  logic    rdy;
  logic    flush;
  logic    alloc_from_issuer;
  reg_id_t rd_from_issuer;
  rob_id_t dest_to_issuer;
  logic    full_to_issuer;
  logic    cdb_valid;
  rob_id_t cdb_dest;
  reg_t    cdb_value;
  logic    commit_valid_to_reg_file;
  reg_id_t commit_rd_to_reg_file;
  reg_t    commit_value_to_reg_file;
  rob_id_t commit_dest_to_reg_file;
`ifdef ROB_FORWARD_EN
  rob_id_t qj_query;
  rob_id_t qk_query;
  reg_t    vj_fwd;
  reg_t    vk_fwd;
  logic    rj_fwd;
  logic    rk_fwd;

  modport master (
    input  rdy, flush, alloc_from_issuer, rd_from_issuer,
           cdb_valid, cdb_dest, cdb_value, qj_query, qk_query,
    output dest_to_issuer, full_to_issuer,
           commit_valid_to_reg_file, commit_rd_to_reg_file,
           commit_value_to_reg_file, commit_dest_to_reg_file,
           vj_fwd, vk_fwd, rj_fwd, rk_fwd
  );
  modport slave (
    output rdy, flush, alloc_from_issuer, rd_from_issuer,
           cdb_valid, cdb_dest, cdb_value, qj_query, qk_query,
    input  dest_to_issuer, full_to_issuer,
           commit_valid_to_reg_file, commit_rd_to_reg_file,
           commit_value_to_reg_file, commit_dest_to_reg_file,
           vj_fwd, vk_fwd, rj_fwd, rk_fwd
  );
`else
  modport master (
    input  rdy, flush, alloc_from_issuer, rd_from_issuer,
           cdb_valid, cdb_dest, cdb_value,
    output dest_to_issuer, full_to_issuer,
           commit_valid_to_reg_file, commit_rd_to_reg_file,
           commit_value_to_reg_file, commit_dest_to_reg_file
  );
  modport slave (
    output rdy, flush, alloc_from_issuer, rd_from_issuer,
           cdb_valid, cdb_dest, cdb_value,
    input  dest_to_issuer, full_to_issuer,
           commit_valid_to_reg_file, commit_rd_to_reg_file,
           commit_value_to_reg_file, commit_dest_to_reg_file
  );
`endif
endinterface

// File: rtl/ro_buffer.sv
// ro_buffer: in-order reorder buffer.
//   Hands the issuer a nonzero rename tag per instruction, captures results
//   from the CDB and retires entries in program order, one per cycle, to the
//   register file. Tag 0 is reserved for "no dependency / value ready".
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   ro_buffer_if.master (issuer alloc, CDB, commit_* to reg file)
// Optional feature macro: ROB_FORWARD_EN adds qj/qk operand forwarding.
module ro_buffer
  import ro_buffer_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ro_buffer_if.master bus
);

  rob_entry_t slots [ROB_SIZE];
  rob_id_t    head, tail;
  rob_cnt_t   count;

  logic    commit_valid_q;
  reg_id_t commit_rd_q;
  reg_t    commit_value_q;
  rob_id_t commit_dest_q;

  // Pointers live in 1..ROB_SIZE-1; tag 0 is never handed out.
  function automatic rob_id_t next_ptr(rob_id_t p);
    return (p == ROB_LAST) ? ROB_FIRST : p + rob_id_t'(1);
  endfunction

  logic full, do_alloc, cdb_hit, do_commit;

  assign full      = (count == ROB_CAP);
  assign do_alloc  = bus.alloc_from_issuer && !full;
  assign cdb_hit   = bus.cdb_valid && (bus.cdb_dest != ROB_NULL) && slots[bus.cdb_dest].busy;
  // Uses the ready bit latched before this edge, so a CDB write needs a full
  // cycle before the entry can retire.
  assign do_commit = slots[head].busy && slots[head].ready;

  assign bus.dest_to_issuer           = tail;
  assign bus.full_to_issuer           = full;
  assign bus.commit_valid_to_reg_file = commit_valid_q;
  assign bus.commit_rd_to_reg_file    = commit_rd_q;
  assign bus.commit_value_to_reg_file = commit_value_q;
  assign bus.commit_dest_to_reg_file  = commit_dest_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= ROB_FIRST;
      tail           <= ROB_FIRST;
      count          <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_dest_q  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) slots[i] <= '0;
    end else if (!bus.rdy) begin
      commit_valid_q <= 1'b0;
    end else if (bus.flush) begin
      head           <= ROB_FIRST;
      tail           <= ROB_FIRST;
      count          <= '0;
      commit_valid_q <= 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        slots[i].busy  <= 1'b0;
        slots[i].ready <= 1'b0;
      end
    end else begin
      // Alloc only targets a non-busy slot, so it never collides with the CDB
      // write; the commit clear is last so it wins over a late CDB to head.
      if (cdb_hit) begin
        slots[bus.cdb_dest].value <= bus.cdb_value;
        slots[bus.cdb_dest].ready <= 1'b1;
      end
      if (do_alloc) begin
        slots[tail].busy  <= 1'b1;
        slots[tail].ready <= 1'b0;
        slots[tail].rd    <= bus.rd_from_issuer;
        tail              <= next_ptr(tail);
      end
      if (do_commit) begin
        commit_valid_q    <= 1'b1;
        commit_rd_q       <= slots[head].rd;
        commit_value_q    <= slots[head].value;
        commit_dest_q     <= head;
        slots[head].busy  <= 1'b0;
        slots[head].ready <= 1'b0;
        head              <= next_ptr(head);
      end else begin
        commit_valid_q <= 1'b0;
      end
      count <= count + rob_cnt_t'(do_alloc) - rob_cnt_t'(do_commit);
    end
  end

`ifdef ROB_FORWARD_EN
  // A same-cycle CDB broadcast takes precedence over the stored value.
  function automatic fwd_t lookup(rob_id_t q, logic cv, rob_id_t cd, reg_t cval,
                                  rob_entry_t e);
    fwd_t f;
    f.hit   = 1'b0;
    f.value = '0;
    if (cv && (cd == q)) begin
      f.hit   = 1'b1;
      f.value = cval;
    end else if (e.busy && e.ready) begin
      f.hit   = 1'b1;
      f.value = e.value;
    end
    return f;
  endfunction

  fwd_t fj, fk;
  assign fj = lookup(bus.qj_query, bus.cdb_valid, bus.cdb_dest, bus.cdb_value, slots[bus.qj_query]);
  assign fk = lookup(bus.qk_query, bus.cdb_valid, bus.cdb_dest, bus.cdb_value, slots[bus.qk_query]);
  assign bus.rj_fwd = fj.hit;
  assign bus.vj_fwd = fj.value;
  assign bus.rk_fwd = fk.hit;
  assign bus.vk_fwd = fk.value;
`endif

endmodule

// File: tb/tb_ro_buffer.sv
module tb_ro_buffer;
  import ro_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ro_buffer_if bus ();
  ro_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_from_issuer = 1'b0;
    bus.cdb_valid         = 1'b0;
    bus.flush             = 1'b0;
  endtask

  initial begin
    int      t;
    rob_id_t tt;
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.flush = 1'b0;
    bus.alloc_from_issuer = 1'b0;
    bus.rd_from_issuer = '0;
    bus.cdb_valid = 1'b0;
    bus.cdb_dest = '0;
    bus.cdb_value = '0;
`ifdef ROB_FORWARD_EN
    bus.qj_query = '0;
    bus.qk_query = '0;
`endif
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_dest",  bus.dest_to_issuer, 1);
    check("rst_full",  bus.full_to_issuer, 0);
    check("rst_cv",    bus.commit_valid_to_reg_file, 0);
    check("rst_crd",   bus.commit_rd_to_reg_file, 0);
    check("rst_cval",  bus.commit_value_to_reg_file, 0);
    check("rst_cdest", bus.commit_dest_to_reg_file, 0);
    check("rst_count", dut.count, 0);

    // three allocations rd=5,6,7
    bus.alloc_from_issuer = 1'b1;
    bus.rd_from_issuer = 5'd5; step(); check("a1_dest", bus.dest_to_issuer, 2);
    bus.rd_from_issuer = 5'd6; step(); check("a2_dest", bus.dest_to_issuer, 3);
    bus.rd_from_issuer = 5'd7; step(); check("a3_dest", bus.dest_to_issuer, 4);
    idle();
    check("a3_count", dut.count, 3);
    check("a3_cv", bus.commit_valid_to_reg_file, 0);

    // out-of-order completion, in-order retirement
    bus.cdb_valid = 1'b1; bus.cdb_dest = 4'd2; bus.cdb_value = 32'hBB;
    step(); check("cdb2_cv", bus.commit_valid_to_reg_file, 0);
    bus.cdb_dest = 4'd1; bus.cdb_value = 32'hAA;
    step(); check("cdb1_cv", bus.commit_valid_to_reg_file, 0);
    idle();
    step();
    check("c1_cv",   bus.commit_valid_to_reg_file, 1);
    check("c1_rd",   bus.commit_rd_to_reg_file, 5);
    check("c1_val",  bus.commit_value_to_reg_file, 32'hAA);
    check("c1_dest", bus.commit_dest_to_reg_file, 1);
    step();
    check("c2_cv",   bus.commit_valid_to_reg_file, 1);
    check("c2_rd",   bus.commit_rd_to_reg_file, 6);
    check("c2_val",  bus.commit_value_to_reg_file, 32'hBB);
    check("c2_dest", bus.commit_dest_to_reg_file, 2);
    step();
    check("c3_held", bus.commit_valid_to_reg_file, 0);
    check("c3_count", dut.count, 1);
    check("c3_head", dut.head, 3);
    bus.cdb_valid = 1'b1; bus.cdb_dest = 4'd3; bus.cdb_value = 32'h33;
    step(); idle(); step();
    check("c3_cv",  bus.commit_valid_to_reg_file, 1);
    check("c3_rd",  bus.commit_rd_to_reg_file, 7);
    check("c3_val", bus.commit_value_to_reg_file, 32'h33);
    step();
    check("drain_count", dut.count, 0);
    check("drain_cv", bus.commit_valid_to_reg_file, 0);

    // fill all 15 entries starting at tag 4
    bus.alloc_from_issuer = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.rd_from_issuer = reg_id_t'(i + 1);
      step();
    end
    check("fill_full", bus.full_to_issuer, 1);
    check("fill_count", dut.count, 15);
    check("fill_dest", bus.dest_to_issuer, 4);
    bus.rd_from_issuer = 5'd9;
    step();
    check("ovf_dest", bus.dest_to_issuer, 4);
    check("ovf_count", dut.count, 15);
    check("ovf_full", bus.full_to_issuer, 1);
    bus.alloc_from_issuer = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_dest = 4'd4; bus.cdb_value = 32'h44;
    step();
    bus.cdb_valid = 1'b0;
    bus.alloc_from_issuer = 1'b1;
    step();
    check("fc_cv",    bus.commit_valid_to_reg_file, 1);
    check("fc_cdest", bus.commit_dest_to_reg_file, 4);
    check("fc_crd",   bus.commit_rd_to_reg_file, 1);
    check("fc_dest",  bus.dest_to_issuer, 4);
    check("fc_count", dut.count, 14);
    step();
    check("retry_dest",  bus.dest_to_issuer, 5);
    check("retry_count", dut.count, 15);
    check("retry_full",  bus.full_to_issuer, 1);
    idle();

    // flush from full
    bus.flush = 1'b1; step(); idle();
    check("fl0_count", dut.count, 0);
    check("fl0_dest",  bus.dest_to_issuer, 1);
    check("fl0_head",  dut.head, 1);

    // flush with 4 entries, colliding with CDB/alloc/commit
    bus.alloc_from_issuer = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_from_issuer = reg_id_t'(i + 1);
      step();
    end
    bus.alloc_from_issuer = 1'b0;
    check("pre_fl_dest", bus.dest_to_issuer, 5);
    bus.cdb_valid = 1'b1; bus.cdb_dest = 4'd1; bus.cdb_value = 32'h11;
    step();
    bus.flush = 1'b1; bus.cdb_dest = 4'd2; bus.cdb_value = 32'h22;
    bus.alloc_from_issuer = 1'b1;
    step(); idle();
    check("fl_count", dut.count, 0);
    check("fl_head",  dut.head, 1);
    check("fl_dest",  bus.dest_to_issuer, 1);
    check("fl_cv",    bus.commit_valid_to_reg_file, 0);
    step(); check("fl_cv1", bus.commit_valid_to_reg_file, 0);
    step(); check("fl_cv2", bus.commit_valid_to_reg_file, 0);

    // 20 alloc/CDB/commit rounds across the wrap
    t = 1;
    for (int r = 0; r < 20; r++) begin
      tt = rob_id_t'(t);
      check("wr_dest", bus.dest_to_issuer, t);
      bus.alloc_from_issuer = 1'b1; bus.rd_from_issuer = reg_id_t'(r);
      step();
      bus.alloc_from_issuer = 1'b0;
      bus.cdb_valid = 1'b1; bus.cdb_dest = tt; bus.cdb_value = 32'h1000 + r;
      step();
      bus.cdb_valid = 1'b0;
      step();
      check("wr_cv",   bus.commit_valid_to_reg_file, 1);
      check("wr_cdst", bus.commit_dest_to_reg_file, t);
      check("wr_crd",  bus.commit_rd_to_reg_file, r);
      check("wr_cval", bus.commit_value_to_reg_file, 32'h1000 + r);
      t = (t == 15) ? 1 : t + 1;
    end
    check("wr_final_dest", bus.dest_to_issuer, 6);
    check("wr_count", dut.count, 0);

    // rdy low for 3 cycles mid-stream
    bus.alloc_from_issuer = 1'b1;
    bus.rd_from_issuer = 5'd10; step();
    bus.rd_from_issuer = 5'd11; step();
    bus.alloc_from_issuer = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_dest = 4'd6; bus.cdb_value = 32'h66;
    step();
    bus.rdy = 1'b0;
    bus.cdb_dest = 4'd7; bus.cdb_value = 32'h77;
    bus.alloc_from_issuer = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_cv",   bus.commit_valid_to_reg_file, 0);
      check("frz_dest", bus.dest_to_issuer, 8);
      check("frz_head", dut.head, 6);
    end
    bus.rdy = 1'b1; idle();
    step();
    check("res_cv",   bus.commit_valid_to_reg_file, 1);
    check("res_cdst", bus.commit_dest_to_reg_file, 6);
    check("res_crd",  bus.commit_rd_to_reg_file, 10);
    check("res_cval", bus.commit_value_to_reg_file, 32'h66);
    step();
    check("res_hold7", bus.commit_valid_to_reg_file, 0);
    bus.cdb_valid = 1'b1; bus.cdb_dest = 4'd7; bus.cdb_value = 32'h77;
    step(); idle(); step();
    check("res7_cv",   bus.commit_valid_to_reg_file, 1);
    check("res7_cdst", bus.commit_dest_to_reg_file, 7);
    check("res7_crd",  bus.commit_rd_to_reg_file, 11);
    check("res7_count", dut.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
